ps2_recepteur: RTL and testbench

PS2_RECEPTEUR -- requirements
Module: ps2_recepteur

---
 rtl/ps2_recepteur.sv | 186 ++++++++++++++++++
 tb/tb_ps2_recepteur.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_recepteur.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, decodes 11-bit frames,
// and publishes make codes with E0 (extended) and F0 (break) prefix handling.
module ps2_recepteur #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       data_lu,
    output logic [7:0] data_out,
    output logic       data_valide,
    output logic       etendu,
    output logic       erreur,
    output logic       debordement
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout;
    logic          frame_ok;
    logic          casse_q, casse_d, ext_q, ext_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valide_q, valide_d, etendu_q, etendu_d;
    logic          erreur_q, erreur_d, deb_q, deb_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign strobe  = filt_prev_q & ~filt_q;
    assign timeout = (state_q != S_IDLE) && !strobe && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        casse_d    = casse_q;
        ext_d      = ext_q;
        data_out_d = data_out_q;
        etendu_d   = etendu_q;
        valide_d   = valide_q & ~data_lu;
        erreur_d   = 1'b0;
        deb_d      = deb_q;
        frame_ok   = 1'b0;

        if (state_q == S_IDLE || strobe) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYC)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if ((^shift_q ^ par_q) && dat_s2_q) frame_ok = 1'b1;
                    else                                 erreur_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (timeout) begin
            state_d  = S_IDLE;
            erreur_d = 1'b1;
            casse_d  = 1'b0;
            ext_d    = 1'b0;
        end

        // Prefix bytes only arm flags; a code after F0 is a break and is dropped.
        if (frame_ok) begin
            if (shift_q == 8'hF0) begin
                casse_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                casse_d = 1'b0;
                ext_d   = 1'b0;
                if (!casse_q) begin
                    data_out_d = shift_q;
                    etendu_d   = ext_q;
                    valide_d   = 1'b1;
                    if (valide_q && !data_lu) deb_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            casse_q     <= 1'b0;
            ext_q       <= 1'b0;
            data_out_q  <= 8'h00;
            etendu_q    <= 1'b0;
            valide_q    <= 1'b0;
            erreur_q    <= 1'b0;
            deb_q       <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            casse_q     <= casse_d;
            ext_q       <= ext_d;
            data_out_q  <= data_out_d;
            etendu_q    <= etendu_d;
            valide_q    <= valide_d;
            erreur_q    <= erreur_d;
            deb_q       <= deb_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valide = valide_q;
    assign etendu      = etendu_q;
    assign erreur      = erreur_q;
    assign debordement = deb_q;

endmodule

// File: tb/tb_ps2_recepteur.sv
// Bench for ps2_recepteur: drives PS/2 frames, checks publications against a queue of
// expected {etendu, data_out} pairs, and checks error pulses, overrun and reset behaviour.
module tb_ps2_recepteur;

    localparam int FLEN = 4;
    localparam int TOUT = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_data, data_lu;
    logic [7:0] data_out;
    logic       data_valide, etendu, erreur, debordement;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    logic [8:0] pubq[$];

    ps2_recepteur #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data_lu(data_lu), .data_out(data_out), .data_valide(data_valide),
        .etendu(etendu), .erreur(erreur), .debordement(debordement)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // A publication is a rising data_valide or a change of the presented code while valid.
    logic       vprev = 1'b0, eprev = 1'b0, errprev = 1'b0;
    logic [7:0] dprev = 8'h00;
    logic [8:0] exp_pub;
    always @(negedge clk) begin
        if (data_valide && (!vprev || data_out !== dprev || etendu !== eprev)) begin
            checks++;
            if (pubq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pub got=%h ext=%0b expected none", data_out, etendu);
            end else begin
                exp_pub = pubq.pop_front();
                if ({etendu, data_out} !== exp_pub) begin
                    failures++;
                    $display("FAIL pub_value got=%h ext=%0b expected=%h ext=%0b",
                             data_out, etendu, exp_pub[7:0], exp_pub[8]);
                end
            end
        end
        if (erreur) begin
            err_cnt++;
            checks++;
            if (errprev) begin
                failures++;
                $display("FAIL erreur_width got=2+ cycles expected=1");
            end
        end
        vprev   = data_valide;
        dprev   = data_out;
        eprev   = etendu;
        errprev = erreur;
    end

    // mode 1: check publication timing on the last bit; mode 2: ack in the publication cycle.
    task automatic send_bits(input logic [10:0] v, input int n, input bit glitch, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = v[i];
            repeat (4) @(negedge clk);
            if (glitch) begin
                ps2_clk = 1'b0;
                repeat (FLEN - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (4) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == n - 1 && mode != 0) begin
                // strobe visible after 2 sync + FLEN filter edges, publication one edge later
                repeat (2 + FLEN) @(posedge clk);
                #1;
                if (mode == 1) begin
                    checks++;
                    if (data_valide !== 1'b0) begin
                        failures++;
                        $display("FAIL pub_latency_early got=%0b expected=0", data_valide);
                    end
                end else begin
                    data_lu = 1'b1;
                end
                @(posedge clk);
                #1;
                data_lu = 1'b0;
                if (mode == 1) begin
                    checks++;
                    if (data_valide !== 1'b1) begin
                        failures++;
                        $display("FAIL pub_latency got=%0b expected=1", data_valide);
                    end
                end
            end
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int mode);
        logic p;
        p = bad_par ? ^b : ~^b;
        send_bits({~bad_stop, p, b, 1'b0}, 11, glitch, mode);
    endtask

    task automatic ack();
        @(negedge clk) data_lu = 1'b1;
        @(negedge clk) data_lu = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_state(input string name, input logic [7:0] exp_d);
        checks++;
        if (data_valide !== 1'b0 || data_out !== exp_d) begin
            failures++;
            $display("FAIL %s got valid=%0b data=%h expected valid=0 data=%h",
                     name, data_valide, data_out, exp_d);
        end
        checks++;
        if (pubq.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got=%0d expected=0", name, pubq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; data_lu = 1'b0;
        #2;
        checks++;
        if ({data_out, data_valide, etendu, erreur, debordement} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%0b/%0b/%0b/%0b expected=00/0/0/0/0",
                     data_out, data_valide, etendu, erreur, debordement);
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        pubq.push_back({1'b0, 8'h16});
        send_frame(8'h16, 0, 0, 0, 1);
        checks++;
        if (etendu !== 1'b0) begin
            failures++;
            $display("FAIL basic_etendu got=%0b expected=0", etendu);
        end
        repeat (3) @(negedge clk);
        ack();
        check_idle_state("basic_ack", 8'h16);
    endtask

    task automatic test_break();
        pubq.push_back({1'b0, 8'h1E});
        send_frame(8'h1E, 0, 0, 0, 0);
        ack();
        send_frame(8'hF0, 0, 0, 0, 0);
        send_frame(8'h1E, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        check_idle_state("break", 8'h1E);
    endtask

    task automatic test_extended();
        pubq.push_back({1'b1, 8'h75});
        send_frame(8'hE0, 0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0, 0);
        checks++;
        if (etendu !== 1'b1 || data_out !== 8'h75) begin
            failures++;
            $display("FAIL ext_75 got=%h ext=%0b expected=75 ext=1", data_out, etendu);
        end
        ack();
        checks++;
        if (etendu !== 1'b1) begin
            failures++;
            $display("FAIL ext_hold got=%0b expected=1", etendu);
        end
        pubq.push_back({1'b0, 8'h72});
        send_frame(8'h72, 0, 0, 0, 0);
        ack();
        check_idle_state("ext_72", 8'h72);
    endtask

    task automatic test_errors();
        int e0;
        e0 = err_cnt;
        send_frame(8'h16, 1, 0, 0, 0);
        checks++;
        if (err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL parity_err got=%0d expected=1", err_cnt - e0);
        end
        check_idle_state("parity", 8'h72);
        send_frame(8'h1E, 0, 1, 0, 0);
        checks++;
        if (err_cnt - e0 != 2) begin
            failures++;
            $display("FAIL stop_err got=%0d expected=2", err_cnt - e0);
        end
        check_idle_state("stop", 8'h72);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_bits(11'b000_0110_1100, 4, 0, 0);
        repeat (TOUT + 20) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL timeout_err got=%0d expected=1", err_cnt - e0);
        end
        pubq.push_back({1'b0, 8'h16});
        send_frame(8'h16, 0, 0, 0, 0);
        ack();
        check_idle_state("after_timeout", 8'h16);
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_cnt;
        pubq.push_back({1'b0, 8'h1E});
        send_frame(8'h1E, 0, 0, 1, 0);
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL glitch_err got=%0d expected=0", err_cnt - e0);
        end
        ack();
        check_idle_state("glitch", 8'h1E);
    endtask

    task automatic test_back_to_back();
        pubq.push_back({1'b0, 8'h16});
        send_frame(8'h16, 0, 0, 0, 0);
        pubq.push_back({1'b0, 8'h1E});
        send_frame(8'h1E, 0, 0, 0, 2);
        checks++;
        if (data_valide !== 1'b1 || debordement !== 1'b0 || data_out !== 8'h1E) begin
            failures++;
            $display("FAIL ack_vs_pub got valid=%0b deb=%0b data=%h expected valid=1 deb=0 data=1e",
                     data_valide, debordement, data_out);
        end
        ack();
        check_idle_state("b2b", 8'h1E);
    endtask

    task automatic test_overrun();
        pubq.push_back({1'b0, 8'h16});
        send_frame(8'h16, 0, 0, 0, 0);
        pubq.push_back({1'b0, 8'h1E});
        send_frame(8'h1E, 0, 0, 0, 0);
        checks++;
        if (data_out !== 8'h1E || debordement !== 1'b1 || data_valide !== 1'b1) begin
            failures++;
            $display("FAIL overrun got data=%h deb=%0b valid=%0b expected data=1e deb=1 valid=1",
                     data_out, debordement, data_valide);
        end
        ack();
        checks++;
        if (debordement !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%0b expected=1", debordement);
        end
    endtask

    task automatic test_reset_midframe();
        send_bits(11'b000_0110_1100, 5, 0, 0);
        @(negedge clk) reset = 1'b1;
        #2;
        checks++;
        if ({data_out, data_valide, etendu, erreur, debordement} !== 12'h000) begin
            failures++;
            $display("FAIL midreset got=%h/%0b/%0b/%0b/%0b expected=00/0/0/0/0",
                     data_out, data_valide, etendu, erreur, debordement);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pubq.push_back({1'b0, 8'h16});
        send_frame(8'h16, 0, 0, 0, 0);
        ack();
        check_idle_state("after_reset", 8'h16);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_break();
        test_extended();
        test_errors();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
